stage_5_writeback: RTL and testbench
====================================

// Module: stage_5_writeback
// PURPOSE
// - MEM/WB pipeline register and write-back stage.
// - Latches MEM-stage results and selects the write-back value (ALU result or load data).
// - Drives write_data / write_enable / write_back_rd into the decode-stage Register_File write port.
// - Keeps a one-entry history of the last committed write and returns bypass data for the
//   decode-stage rs/rt reads.
// - Counts retired instructions.
// PARAMETERS
// - DATA_W  32  data path width
// - ADDR_W   5  register index width
// - CNT_W   32  retire counter width
// PORTS
// - clk              in   1        rising-edge clock
// - rst              in   1        asynchronous, active-high reset
// - in_valid         in   1        MEM stage presents a valid instruction
// - in_mem_to_reg    in   1        1 = write back mem_data, 0 = write back alu_result
// - in_reg_write     in   1        instruction writes a register
// - in_alu_result    in   DATA_W   ALU result from EX/MEM
// - in_mem_data      in   DATA_W   load data from data memory
// - in_rd            in   ADDR_W   destination register
// - stall            in   1        hold the stage contents
// - flush            in   1        invalidate the stage contents
// - rs, rt           in   ADDR_W   decode-stage read indices (bypass lookup)
// - write_data       out  DATA_W   to Register_File write data
// - write_enable     out  1        to Register_File write enable
// - write_back_rd    out  ADDR_W   to Register_File write index
// - bypass_sel1/2    out  2        00 none, 01 current write, 10 history entry
// - bypass_data1/2   out  DATA_W   bypass value for rs/rt
// - retire_count     out  CNT_W    committed-instruction count
// BEHAVIOUR
// - Clock and reset: one clock, clk. rst is asynchronous and active-high.
// - Reset values: on rst, every stage register, done_q, the history entry and retire_count clear
//   to 0, so every output is 0 (bypass_sel = 00).
// - Stage register update, on posedge clk, in priority order:
//   1. flush: valid_q <= 0, done_q <= 0. Flush wins over stall.
//   2. stall: all _q fields hold. done_q <= valid_q (set after the first cycle).
//   3. otherwise: capture the in_* signals into the _q fields, done_q <= 0.
// - Latency: an instruction enters at edge N and drives the RF during cycle N..N+1.
//   The RF writes at edge N+1.
// - commit = valid_q & ~done_q. An instruction stalled for k cycles commits exactly once,
//   in its first cycle.
// - Write port:
//   - write_enable = commit & reg_write_q & (rd_q != 0). Writes to $0 are never issued.
//   - write_data = mem_to_reg_q ? mem_data_q : alu_result_q.
//   - write_back_rd = rd_q. write_data and write_back_rd may be non-zero while
//     write_enable = 0 (don't-care).
// - History entry: when write_enable = 1 at a posedge, capture (hist_valid = 1, hist_rd, hist_data).
//   Otherwise hold. flush does not clear the history entry.
// - Bypass (combinational), shown for rs; rt is identical with sel2/data2:
//   - rs == 0: sel 00, data 0.
//   - else write_enable && write_back_rd == rs: sel 01, data write_data.
//     The current write beats the history entry.
//   - else hist_valid && hist_rd == rs: sel 10, data hist_data.
//   - else: sel 00, data 0.
// - Retire counter: retire_count increments by 1 on each posedge with commit = 1, including
//   instructions with reg_write = 0. It wraps modulo 2^CNT_W.
// - Reset mid-stall: all state clears immediately. No write is issued after rst rises.
// - Simultaneous flush and in_valid: the incoming instruction is dropped.
// TESTING
// - Writeback mux: in_valid=1, reg_write=1, mem_to_reg=0, alu=0x1234, rd=5 -> next cycle
//   write_enable=1, write_data=0x1234, write_back_rd=5. Repeat with mem_to_reg=1, mem_data=0xBEEF
//   -> write_data=0xBEEF.
// - $0 guard: reg_write=1, rd=0 -> write_enable stays 0; retire_count still +1.
// - Stall: stall held 3 cycles on a valid write to rd=7 -> write_enable high for exactly 1 cycle;
//   retire_count +1 only.
// - Flush priority: flush=1 with stall=1 and in_valid=1 -> valid_q=0, write_enable=0 next cycle,
//   no retire.
// - Bypass: write 0xAA to r3, then 0xBB to r3 next cycle, rs=3 -> sel1=01, data1=0xBB in the
//   second cycle. The cycle after, sel1=10, data1=0xBB. With rt=4, sel2=00.
// - Reset/wrap: CNT_W=4, 16 commits -> retire_count wraps to 0. Assert rst mid-stream ->
//   all outputs 0 asynchronously.

Source files
------------

// File: rtl/stage_5_writeback.sv
// -----------------------------------------------------------------------------
// stage_5_writeback
//
// MEM/WB pipeline register plus write-back stage.
//   * Latches the MEM-stage result bundle (valid, mem_to_reg, reg_write,
//     alu_result, mem_data, rd) and picks the write-back value.
//   * Drives the Register_File write port (write_data / write_enable /
//     write_back_rd).
//   * Keeps a one-entry history of the last committed register write and
//     answers the decode stage's rs/rt bypass lookups from either the write
//     currently on the port or that history entry.
//   * Counts retired (committed) instructions, wrapping modulo 2^CNT_W.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_valid ... in_rd    MEM-stage instruction bundle
//   stall                 hold the stage contents
//   flush                 invalidate the stage contents (wins over stall)
//   rs, rt                decode-stage read indices for the bypass lookup
//   write_data            Register_File write data
//   write_enable          Register_File write enable
//   write_back_rd         Register_File write index
//   bypass_sel1/2         00 none, 01 current write, 10 history entry
//   bypass_data1/2        bypass value for rs / rt
//   retire_count          committed-instruction count
//
// Handshake: there is no ready path back to MEM. An instruction is accepted
// on every rising edge where stall and flush are both low; in_valid qualifies
// the bundle. stall holds the stage, flush empties it. An instruction held by
// stall commits once only, in its first cycle in the stage.
// -----------------------------------------------------------------------------
module stage_5_writeback #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_mem_to_reg,
    input  logic              in_reg_write,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_mem_data,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] write_data,
    output logic              write_enable,
    output logic [ADDR_W-1:0] write_back_rd,
    output logic [1:0]        bypass_sel1,
    output logic [DATA_W-1:0] bypass_data1,
    output logic [1:0]        bypass_sel2,
    output logic [DATA_W-1:0] bypass_data2,
    output logic [CNT_W-1:0]  retire_count
);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_CURR = 2'b01;
    localparam logic [1:0] SEL_HIST = 2'b10;

    // ---------------------------------------------------------------------
    // Stage register
    // ---------------------------------------------------------------------
    logic              valid_q,      valid_d;
    logic              done_q,       done_d;
    logic              mem_to_reg_q, mem_to_reg_d;
    logic              reg_write_q,  reg_write_d;
    logic [DATA_W-1:0] alu_result_q, alu_result_d;
    logic [DATA_W-1:0] mem_data_q,   mem_data_d;
    logic [ADDR_W-1:0] rd_q,         rd_d;

    // History of the last committed write
    logic              hist_valid_q, hist_valid_d;
    logic [ADDR_W-1:0] hist_rd_q,    hist_rd_d;
    logic [DATA_W-1:0] hist_data_q,  hist_data_d;

    // Retire counter
    logic [CNT_W-1:0]  retire_q,     retire_d;

    logic              commit;
    logic              we;
    logic [DATA_W-1:0] wb_value;

    always_comb begin
        valid_d      = valid_q;
        done_d       = done_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        alu_result_d = alu_result_q;
        mem_data_d   = mem_data_q;
        rd_d         = rd_q;

        if (flush) begin
            // Flush beats stall and drops any incoming instruction. The data
            // fields are left alone; they are meaningless without valid_q.
            valid_d = 1'b0;
            done_d  = 1'b0;
        end else if (stall) begin
            // After one cycle in the stage the held instruction has committed;
            // done_q stops it committing again while the stall lasts.
            done_d = valid_q;
        end else begin
            valid_d      = in_valid;
            done_d       = 1'b0;
            mem_to_reg_d = in_mem_to_reg;
            reg_write_d  = in_reg_write;
            alu_result_d = in_alu_result;
            mem_data_d   = in_mem_data;
            rd_d         = in_rd;
        end
    end

    // ---------------------------------------------------------------------
    // Commit / write port
    // ---------------------------------------------------------------------
    always_comb begin
        commit   = valid_q & ~done_q;
        // $0 is hard-wired to zero, so a write to it is never issued.
        we       = commit & reg_write_q & (rd_q != '0);
        wb_value = mem_to_reg_q ? mem_data_q : alu_result_q;
    end

    always_comb begin
        hist_valid_d = hist_valid_q;
        hist_rd_d    = hist_rd_q;
        hist_data_d  = hist_data_q;
        // The history entry survives flush: the write it records really
        // happened in the register file.
        if (we) begin
            hist_valid_d = 1'b1;
            hist_rd_d    = rd_q;
            hist_data_d  = wb_value;
        end
    end

    always_comb begin
        retire_d = retire_q;
        // Every committed instruction retires, register write or not.
        if (commit) begin
            retire_d = retire_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q      <= 1'b0;
            done_q       <= 1'b0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            alu_result_q <= '0;
            mem_data_q   <= '0;
            rd_q         <= '0;
            hist_valid_q <= 1'b0;
            hist_rd_q    <= '0;
            hist_data_q  <= '0;
            retire_q     <= '0;
        end else begin
            valid_q      <= valid_d;
            done_q       <= done_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            rd_q         <= rd_d;
            hist_valid_q <= hist_valid_d;
            hist_rd_q    <= hist_rd_d;
            hist_data_q  <= hist_data_d;
            retire_q     <= retire_d;
        end
    end

    // ---------------------------------------------------------------------
    // Bypass lookup. The write on the port right now is newer than the
    // history entry, so it wins when both match.
    // ---------------------------------------------------------------------
    function automatic logic [DATA_W+1:0] bypass_lookup(input logic [ADDR_W-1:0] idx);
        logic [DATA_W+1:0] r;
        r = {SEL_NONE, {DATA_W{1'b0}}};
        if (idx == '0) begin
            r = {SEL_NONE, {DATA_W{1'b0}}};
        end else if (we && (rd_q == idx)) begin
            r = {SEL_CURR, wb_value};
        end else if (hist_valid_q && (hist_rd_q == idx)) begin
            r = {SEL_HIST, hist_data_q};
        end
        return r;
    endfunction

    logic [DATA_W+1:0] byp1;
    logic [DATA_W+1:0] byp2;

    always_comb begin
        byp1 = bypass_lookup(rs);
        byp2 = bypass_lookup(rt);
    end

    assign bypass_sel1   = byp1[DATA_W+1:DATA_W];
    assign bypass_data1  = byp1[DATA_W-1:0];
    assign bypass_sel2   = byp2[DATA_W+1:DATA_W];
    assign bypass_data2  = byp2[DATA_W-1:0];

    assign write_data    = wb_value;
    assign write_enable  = we;
    assign write_back_rd = rd_q;
    assign retire_count  = retire_q;

endmodule

// File: tb/tb_stage_5_writeback.sv
module tb_stage_5_writeback;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          in_valid, in_mem_to_reg, in_reg_write, stall, flush;
  logic [DW-1:0] in_alu_result, in_mem_data;
  logic [AW-1:0] in_rd, rs, rt;
  logic [DW-1:0] write_data, bypass_data1, bypass_data2;
  logic          write_enable;
  logic [AW-1:0] write_back_rd;
  logic [1:0]    bypass_sel1, bypass_sel2;
  logic [CW-1:0] retire_count;

  stage_5_writeback #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_alu_result(in_alu_result), .in_mem_data(in_mem_data), .in_rd(in_rd),
    .stall(stall), .flush(flush), .rs(rs), .rt(rt),
    .write_data(write_data), .write_enable(write_enable), .write_back_rd(write_back_rd),
    .bypass_sel1(bypass_sel1), .bypass_data1(bypass_data1),
    .bypass_sel2(bypass_sel2), .bypass_data2(bypass_data2),
    .retire_count(retire_count)
  );

  // ---------------------------------------------------------------------
  // Scoreboard counters and checker
  // ---------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: which instruction sits in the stage, whether it has
  // yet to commit, what the last register write was, and how many
  // instructions have retired.
  // ---------------------------------------------------------------------
  logic          cur_present, cur_fresh, cur_m2r, cur_rw;
  logic [DW-1:0] cur_alu, cur_md;
  logic [AW-1:0] cur_rd;
  logic          last_valid;
  logic [AW-1:0] last_rd;
  logic [DW-1:0] last_data;
  int unsigned   retired;

  task automatic model_reset();
    cur_present = 0; cur_fresh = 0; cur_m2r = 0; cur_rw = 0;
    cur_alu = '0; cur_md = '0; cur_rd = '0;
    last_valid = 0; last_rd = '0; last_data = '0;
    retired = 0;
  endtask

  function automatic logic [DW-1:0] exp_value();
    return cur_m2r ? cur_md : cur_alu;
  endfunction

  function automatic logic exp_write();
    return cur_present && cur_fresh && cur_rw && (cur_rd != 0);
  endfunction

  function automatic logic [DW+1:0] exp_byp(input logic [AW-1:0] idx);
    if (idx == 0) return '0;
    if (exp_write() && cur_rd == idx) return {2'b01, exp_value()};
    if (last_valid && last_rd == idx) return {2'b10, last_data};
    return '0;
  endfunction

  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    if (exp_write()) begin
      last_valid = 1; last_rd = cur_rd; last_data = exp_value();
    end
    if (cur_present && cur_fresh) retired = (retired + 1) % (1 << CW);
    if (flush) begin
      cur_present = 0; cur_fresh = 0;
    end else if (stall) begin
      cur_fresh = 0;
    end else begin
      cur_present = in_valid; cur_fresh = in_valid;
      cur_m2r = in_mem_to_reg; cur_rw = in_reg_write;
      cur_alu = in_alu_result; cur_md = in_mem_data; cur_rd = in_rd;
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW+1:0] b1, b2;
    b1 = exp_byp(rs);
    b2 = exp_byp(rt);
    chk({tag, ".we"}, 64'(write_enable), 64'(exp_write()));
    if (exp_write()) begin
      chk({tag, ".wdata"}, 64'(write_data), 64'(exp_value()));
      chk({tag, ".wrd"}, 64'(write_back_rd), 64'(cur_rd));
    end
    chk({tag, ".sel1"}, 64'(bypass_sel1), 64'(b1[DW+1:DW]));
    chk({tag, ".data1"}, 64'(bypass_data1), 64'(b1[DW-1:0]));
    chk({tag, ".sel2"}, 64'(bypass_sel2), 64'(b2[DW+1:DW]));
    chk({tag, ".data2"}, 64'(bypass_data2), 64'(b2[DW-1:0]));
    chk({tag, ".retire"}, 64'(retire_count), 64'(retired));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".we0"}, 64'(write_enable), 64'd0);
    chk({tag, ".wdata0"}, 64'(write_data), 64'd0);
    chk({tag, ".wrd0"}, 64'(write_back_rd), 64'd0);
    chk({tag, ".sel1_0"}, 64'(bypass_sel1), 64'd0);
    chk({tag, ".data1_0"}, 64'(bypass_data1), 64'd0);
    chk({tag, ".sel2_0"}, 64'(bypass_sel2), 64'd0);
    chk({tag, ".data2_0"}, 64'(bypass_data2), 64'd0);
    chk({tag, ".retire0"}, 64'(retire_count), 64'd0);
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  int we_pulses = 0;

  task automatic drive(input logic v, input logic m2r, input logic rw,
                       input logic [DW-1:0] alu, input logic [DW-1:0] md,
                       input logic [AW-1:0] rd, input logic st, input logic fl,
                       input logic [AW-1:0] a, input logic [AW-1:0] b);
    in_valid = v; in_mem_to_reg = m2r; in_reg_write = rw;
    in_alu_result = alu; in_mem_data = md; in_rd = rd;
    stall = st; flush = fl; rs = a; rt = b;
  endtask

  task automatic idle();
    drive(0, 0, 0, '0, '0, '0, 0, 0, '0, '0);
  endtask

  // One clock: model follows the edge, outputs checked on the falling edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
    if (write_enable) we_pulses++;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  int unsigned r0;

  initial begin
    model_reset();
    idle();
    @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst = 0;

    // Writeback mux: ALU result, then load data
    drive(1, 0, 1, 32'h1234, 32'h0, 5, 0, 0, 0, 0);
    step("mux_alu");
    chk("mux_alu.we_c", 64'(write_enable), 64'd1);
    chk("mux_alu.wd_c", 64'(write_data), 64'h1234);
    chk("mux_alu.rd_c", 64'(write_back_rd), 64'd5);
    drive(1, 1, 1, 32'h1111, 32'hBEEF, 5, 0, 0, 0, 0);
    step("mux_mem");
    chk("mux_mem.wd_c", 64'(write_data), 64'hBEEF);

    // $0 guard: no write, still retires
    r0 = retire_count;
    drive(1, 0, 1, 32'h5555, 32'h0, 0, 0, 0, 0, 0);
    step("zero_rd");
    chk("zero_rd.we_c", 64'(write_enable), 64'd0);
    idle();
    step("zero_rd_idle");
    chk("zero_rd.retire_c", 64'(retire_count), 64'((r0 + 2) % 16));

    // Stall held 3 cycles: one write pulse, one retire
    drive(1, 0, 1, 32'h77, 32'h0, 7, 0, 0, 0, 0);
    we_pulses = 0;
    r0 = retire_count;
    step("stall_load");
    drive(1, 0, 1, 32'h99, 32'h0, 9, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("stall_hold");
    idle();
    step("stall_release");
    chk("stall.pulses", 64'(we_pulses), 64'd1);
    chk("stall.retire_c", 64'(retire_count), 64'((r0 + 1) % 16));

    // Flush beats stall and drops the incoming instruction
    drive(1, 0, 1, 32'h42, 32'h0, 6, 0, 0, 0, 0);
    step("flush_load");
    drive(1, 0, 1, 32'h43, 32'h0, 8, 1, 1, 0, 0);
    step("flush");
    chk("flush.we_c", 64'(write_enable), 64'd0);
    r0 = retire_count;
    idle();
    step("flush_after");
    chk("flush.retire_c", 64'(retire_count), 64'(r0));

    // Bypass: current write beats history, then history serves
    drive(1, 0, 1, 32'hAA, 32'h0, 3, 0, 0, 3, 4);
    step("byp_aa");
    drive(1, 0, 1, 32'hBB, 32'h0, 3, 0, 0, 3, 4);
    step("byp_bb");
    chk("byp_bb.sel1_c", 64'(bypass_sel1), 64'd1);
    chk("byp_bb.data1_c", 64'(bypass_data1), 64'hBB);
    chk("byp_bb.sel2_c", 64'(bypass_sel2), 64'd0);
    drive(0, 0, 0, '0, '0, '0, 0, 0, 3, 4);
    step("byp_hist");
    chk("byp_hist.sel1_c", 64'(bypass_sel1), 64'd2);
    chk("byp_hist.data1_c", 64'(bypass_data1), 64'hBB);

    // 16 commits wrap the 4-bit counter back to its start value
    r0 = retire_count;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 0, $urandom, $urandom, AW'($urandom_range(0, 7)), 0, 0, 0, 0);
      step("wrap");
    end
    idle();
    step("wrap_end");
    chk("wrap.retire_c", 64'(retire_count), 64'(r0));

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0,
            $urandom, $urandom, AW'($urandom_range(0, 7)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      step("rand");
    end

    // Reset mid-stall: outputs clear without waiting for a clock edge
    drive(1, 1, 1, 32'h0, 32'hCAFE, 9, 0, 0, 9, 0);
    step("rst_load");
    drive(1, 0, 1, 32'h1, 32'h0, 10, 1, 0, 9, 0);
    step("rst_stall");
    #2;
    rst = 1;
    #1;
    model_reset();
    check_zero("async_rst");
    step("rst_held");
    rst = 0;
    for (int i = 0; i < 60; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 1), 1, $urandom, $urandom,
            AW'($urandom_range(0, 7)), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      step("post_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
